// File: rtl/multi_ch_fifo_arbiter_pkg.sv
// Shared types and helpers for the multi-channel FIFO arbiter.
//   arb_state_t : arbiter FSM states
//   clog2_min1  : ceil(log2(n)), never below 1, so one-channel or one-word
//                 configurations still get a 1-bit field
package multi_ch_fifo_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_ch_fifo_arbiter_rr_select.sv
// rr_priority_select: combinational rotating-priority encoder.
//   req   : per-channel request vector
//   last  : index granted last; the search starts at last+1 (mod NUM_CH)
//   valid : at least one request present
//   index : first requesting channel found in rotated order
module rr_priority_select
  import multi_ch_fifo_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic              valid,
  output logic [IW-1:0]     index
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  int                  sh;
  int                  pos;

  // Rotate by doubling the vector, so bit 0 of rot is channel last+1.
  assign dbl = {req, req};

  always_comb begin
    valid = 1'b0;
    index = last;
    pos   = 0;
    sh    = int'(last) + 1;
    rot   = NUM_CH'(dbl >> sh);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        pos   = sh + i;
        if (pos >= NUM_CH) pos = pos - NUM_CH;
        index = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/multi_ch_fifo_arbiter.sv
// multi_ch_fifo_arbiter: N-channel round-robin merge of FWFT FIFOs into one
// word stream, with per-grant burst limit and runtime channel mask.
// Optional build macro CHANNEL_TAG_EN: top TAG_WIDTH bits of each output word
// carry the source channel index.
// Ports:
//   BUS_CLK, BUS_RST   clock, async active-high reset
//   CH_EMPTY/CH_DATA   per-channel FWFT FIFO view (channel i at i*DATA_WIDTH)
//   CH_READ            per-channel pop strobe (one-hot or zero, combinational)
//   CH_ENABLE          runtime grant mask
//   ARB_READY_OUT      downstream accepts the output word this cycle
//   ARB_WRITE_OUT/ARB_DATA_OUT  output register valid/data
//   GRANT_CH           channel currently or last granted
module multi_ch_fifo_arbiter
  import multi_ch_fifo_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                         BUS_CLK,
  input  logic                         BUS_RST,
  input  logic [NUM_CH-1:0]            CH_EMPTY,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DATA,
  output logic [NUM_CH-1:0]            CH_READ,
  input  logic [NUM_CH-1:0]            CH_ENABLE,
  input  logic                         ARB_READY_OUT,
  output logic                         ARB_WRITE_OUT,
  output logic [DATA_WIDTH-1:0]        ARB_DATA_OUT,
  output logic [clog2_min1(NUM_CH)-1:0] GRANT_CH
);

  localparam int CW = clog2_min1(NUM_CH);
  localparam int BW = clog2_min1(BURST_LEN + 1);

  if (NUM_CH < 2 || NUM_CH > 16 || BURST_LEN < 1 ||
      TAG_WIDTH < CW || TAG_WIDTH > DATA_WIDTH) begin : g_param_chk
    $error("multi_ch_fifo_arbiter: illegal parameter combination");
  end

  arb_state_t                           state_q, state_d;
  logic [CW-1:0]                        grant_q, grant_d;
  logic [BW-1:0]                        cnt_q, cnt_d;
  logic                                 out_vld_q;
  logic [DATA_WIDTH-1:0]                out_data_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_word;
  logic [NUM_CH-1:0]                    req;
  logic                                 sel_vld;
  logic [CW-1:0]                        sel_idx;
  logic                                 loadable;
  logic                                 ch_avail;
  logic                                 pop;
  logic [DATA_WIDTH-1:0]                word_in;

  assign ch_word  = CH_DATA;
  assign req      = ~CH_EMPTY & CH_ENABLE;
  // Output register can take a new word if empty or drained this cycle.
  assign loadable = ~out_vld_q | ARB_READY_OUT;
  assign ch_avail = req[grant_q];
  assign pop      = |CH_READ;

`ifdef CHANNEL_TAG_EN
  assign word_in = {TAG_WIDTH'(grant_q), ch_word[grant_q][DATA_WIDTH-TAG_WIDTH-1:0]};
`else
  assign word_in = ch_word[grant_q];
`endif

  rr_priority_select #(.NUM_CH(NUM_CH), .IW(CW)) u_rr (
    .req   (req),
    .last  (grant_q),
    .valid (sel_vld),
    .index (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    CH_READ = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d = sel_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Empty/disabled wins over a pop; a stall holds without counting.
        if (!ch_avail) begin
          state_d = IDLE;
        end else if (loadable) begin
          CH_READ[grant_q] = 1'b1;
          cnt_d            = cnt_q + 1'b1;
          if (cnt_d == BW'(BURST_LEN)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q    <= IDLE;
      grant_q    <= CW'(NUM_CH - 1);
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        out_vld_q  <= 1'b1;
        out_data_q <= word_in;
      end else if (ARB_READY_OUT) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign ARB_WRITE_OUT = out_vld_q;
  assign ARB_DATA_OUT  = out_data_q;
  assign GRANT_CH      = grant_q;

endmodule
